sqrt2_host: RTL and testbench
=============================

Name: sqrt2_host

Overview:
- Initiator side of the half-precision square-root bus: converts a valid/ready operand stream into the single-operand transaction the sqrt2 unit expects, then returns the result and class flags on a valid/ready result stream.
- Owns ENABLE and the operand phase of the shared tristate IO_DATA bus.
- Sits between the FP issue logic and sqrt2; one transaction in flight at a time.

Parameters:
- DRIVE_CYCLES, 1, cycles the host drives the operand on IO_DATA with ENABLE high (1..4).
- TIMEOUT_CYCLES, 32, maximum WAIT cycles before the transaction is aborted (2..255).
- GAP_CYCLES, 1, minimum ENABLE-low cycles between transactions (>=1).

Ports:
- CLK  input  1  clock, all logic on rising edge
- RESET  input  1  synchronous active-high reset
- IN_VALID  input  1  operand available
- IN_READY  output  1  host can accept an operand
- IN_DATA  input  16  binary16 operand
- OUT_VALID  output  1  result available
- OUT_READY  input  1  consumer accepts result
- OUT_DATA  output  16  binary16 result
- OUT_NAN  output  1  captured IS_NAN
- OUT_PINF  output  1  captured IS_PINF
- OUT_NINF  output  1  captured IS_NINF
- OUT_TIMEOUT  output  1  transaction aborted, no RESULT seen
- IO_DATA  inout  16  shared bus to sqrt2
- ENABLE  output  1  transaction enable to sqrt2
- IS_NAN, IS_PINF, IS_NINF  input  1 each  class flags from sqrt2
- RESULT  input  1  sqrt2 result-valid strobe

Behaviour:
- Reset (RESET high at edge): state IDLE; ENABLE=0; IO_DATA released (16'hzzzz); IN_READY=0 during the reset cycle, then 1; OUT_VALID=0; OUT_DATA=0; all OUT_* flags 0; counters 0. Reset mid-transaction drops the operand and takes effect on that same edge. No partial result is ever emitted.
- IO_DATA is driven only in DRIVE, from a registered operand; otherwise high-Z. There is never a same-cycle drive overlap with sqrt2.
- IDLE: IN_READY=1 and ENABLE=0. On IN_VALID&&IN_READY, register IN_DATA and go to DRIVE.
- DRIVE: lasts DRIVE_CYCLES cycles with ENABLE=1 and IO_DATA=operand; then go to WAIT.
- WAIT:
  - ENABLE=1 and IO_DATA released; the wait counter increments each cycle.
  - RESULT===1 at an edge: capture IO_DATA into OUT_DATA and IS_* into OUT_*; set OUT_TIMEOUT=0; go to RESP.
  - X/Z on RESULT is treated as 0.
  - Counter reaches TIMEOUT_CYCLES with no RESULT: set OUT_DATA=16'h7E00 and OUT_NAN=1; clear the other flags; set OUT_TIMEOUT=1; go to RESP.
  - RESULT high on the same edge as expiry: the real result wins and OUT_TIMEOUT=0.
- RESP: ENABLE=0 and OUT_VALID=1. OUT_DATA and the flags stay stable until OUT_READY. On OUT_VALID&&OUT_READY, go to GAP. OUT_VALID drops on the next cycle.
- GAP: ENABLE=0 for GAP_CYCLES cycles, then IDLE. IN_READY stays 0 in DRIVE, WAIT, RESP and GAP.
- Latency: accept edge T. ENABLE and operand are active T+1..T+DRIVE_CYCLES. If RESULT is first sampled high at edge R, OUT_VALID is high in the cycle after R. Minimum operand-to-operand spacing is DRIVE_CYCLES + wait + 1 + GAP_CYCLES + 1.
- IN_VALID while busy is ignored; the operand is not consumed. IN_DATA is sampled only on the accept edge.
- RESULT or flag activity outside WAIT is ignored.

Test Plan:
- Accept 16'h4400 (4.0) with sqrt2 attached. Required: ENABLE high for 1 cycle with the bus driven, then the bus is released; after RESULT, OUT_DATA=16'h4000 and all flags 0. ENABLE is low in the RESP cycle.
- Back-to-back operands 16'h3C00, then 16'h4C00. Required: results 16'h3C00, then 16'h4400. ENABLE is low for at least GAP_CYCLES between transactions, and IN_READY is low throughout the first transaction.
- Special cases:
  - 16'h7C00 -> OUT_DATA=16'h7C00, OUT_PINF=1.
  - 16'hC000 -> OUT_NAN=1.
  - 16'h8000 -> OUT_DATA=16'h8000.
- Responder that never asserts RESULT. Required: exactly TIMEOUT_CYCLES=32 WAIT cycles, then OUT_VALID with OUT_DATA=16'h7E00, OUT_NAN=1, OUT_TIMEOUT=1, and ENABLE=0.
- OUT_READY held low for 5 cycles after OUT_VALID. Required: OUT_DATA and the flags are stable, and IN_READY stays 0. A transfer occurs on the first OUT_READY=1 edge.
- RESET asserted for 1 cycle in mid-WAIT. Required: on the next cycle ENABLE=0, IO_DATA=Z, OUT_VALID=0 and IN_READY=1. A late RESULT pulse afterwards produces no output.

Source files
------------

// File: rtl/sqrt2_host.sv
// Initiator for the half-precision sqrt2 bus: turns a valid/ready operand stream into an ENABLE/IO_DATA transaction.
// Latency: operand on IO_DATA from the cycle after accept; result valid the cycle after RESULT (or after timeout).
// Backpressure: IN_READY only in IDLE; result held stable in RESP until OUT_READY; one transaction in flight.
module sqrt2_host #(
    parameter int DRIVE_CYCLES   = 1,   // 1..4 cycles the operand is driven
    parameter int TIMEOUT_CYCLES = 32,  // 2..255 WAIT cycles before abort
    parameter int GAP_CYCLES     = 1    // >=1 ENABLE-low cycles after a result
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [15:0] IN_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [15:0] OUT_DATA,
    output logic        OUT_NAN,
    output logic        OUT_PINF,
    output logic        OUT_NINF,
    output logic        OUT_TIMEOUT,
    inout  wire  [15:0] IO_DATA,
    output logic        ENABLE,
    input  logic        IS_NAN,
    input  logic        IS_PINF,
    input  logic        IS_NINF,
    input  logic        RESULT
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    // Terminal counts for the shared phase counter (zero-based).
    localparam logic [7:0] DRIVE_LAST   = 8'(DRIVE_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] GAP_LAST     = 8'(GAP_CYCLES - 1);

    // Canonical quiet NaN returned when the unit never answers.
    localparam logic [15:0] TIMEOUT_NAN = 16'h7E00;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] op_q, op_d;
    logic [15:0] out_data_q, out_data_d;
    logic        out_nan_q, out_nan_d;
    logic        out_pinf_q, out_pinf_d;
    logic        out_ninf_q, out_ninf_d;
    logic        out_tmo_q, out_tmo_d;
    logic        result_hit;

    // Only a clean 1 counts as a result strobe; X/Z on the line is not a hit.
    assign result_hit = (RESULT === 1'b1);

    // Bus is owned by the host only while the operand phase is active; the
    // unit may only drive in WAIT, so there is never a cycle with two drivers.
    assign IO_DATA = (state_q == S_DRIVE) ? op_q : 16'hzzzz;

    assign ENABLE      = (state_q == S_DRIVE) || (state_q == S_WAIT);
    assign IN_READY    = (state_q == S_IDLE) && !RESET;
    assign OUT_VALID   = (state_q == S_RESP);
    assign OUT_DATA    = out_data_q;
    assign OUT_NAN     = out_nan_q;
    assign OUT_PINF    = out_pinf_q;
    assign OUT_NINF    = out_ninf_q;
    assign OUT_TIMEOUT = out_tmo_q;

    // Next-state and capture logic for the transaction sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        out_data_d = out_data_q;
        out_nan_d  = out_nan_q;
        out_pinf_d = out_pinf_q;
        out_ninf_d = out_ninf_q;
        out_tmo_d  = out_tmo_q;
        case (state_q)
            S_IDLE: begin
                if (IN_VALID) begin
                    op_d    = IN_DATA;
                    cnt_d   = 8'd0;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT: begin
                // A result arriving on the expiry edge still wins.
                if (result_hit) begin
                    out_data_d = IO_DATA;
                    out_nan_d  = IS_NAN;
                    out_pinf_d = IS_PINF;
                    out_ninf_d = IS_NINF;
                    out_tmo_d  = 1'b0;
                    state_d    = S_RESP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    out_data_d = TIMEOUT_NAN;
                    out_nan_d  = 1'b1;
                    out_pinf_d = 1'b0;
                    out_ninf_d = 1'b0;
                    out_tmo_d  = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                if (OUT_READY) begin
                    cnt_d   = 8'd0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operand on the same edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            op_q       <= 16'd0;
            out_data_q <= 16'd0;
            out_nan_q  <= 1'b0;
            out_pinf_q <= 1'b0;
            out_ninf_q <= 1'b0;
            out_tmo_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            out_data_q <= out_data_d;
            out_nan_q  <= out_nan_d;
            out_pinf_q <= out_pinf_d;
            out_ninf_q <= out_ninf_d;
            out_tmo_q  <= out_tmo_d;
        end
    end

endmodule

// File: tb/tb_sqrt2_host.sv
// Bench for sqrt2_host: behavioural sqrt2 responder, queued expectations, separate result monitor.
// Latency: responder answers a chosen number of WAIT cycles after the operand phase (or never).
// Backpressure: consumer ready is random, forced high, or stalled for a set number of cycles.
module tb_sqrt2_host;

    localparam int DRV = 1;
    localparam int TMO = 32;
    localparam int GAP = 1;

    typedef struct {
        logic [15:0] op;
        int          lat;   // WAIT cycle index of RESULT; negative = never
        logic [15:0] rd;    // data the responder returns
        logic [2:0]  rf;    // {nan, pinf, ninf} the responder returns
    } txn_t;

    logic        clk = 1'b0;
    logic        rst, in_vld, in_rdy, out_vld, out_rdy;
    logic [15:0] in_dat, out_dat;
    logic        out_nan, out_pinf, out_ninf, out_tmo, enable;
    logic        is_nan, is_pinf, is_ninf, result;
    wire  [15:0] io_data;

    logic        bus_drv = 1'b0, prb_drv = 1'b0;
    logic [15:0] bus_val = 16'd0, prb_val = 16'd0;
    logic        res_drv = 1'b0, res_noise = 1'b0, res_man = 1'b0;
    logic [2:0]  rflg = 3'd0;

    assign io_data = bus_drv ? bus_val : (prb_drv ? prb_val : 16'hzzzz);
    assign result  = res_drv | res_noise | res_man;
    assign {is_nan, is_pinf, is_ninf} = rflg;

    txn_t        txq[$];
    logic [19:0] expq[$];
    int          total = 0;
    int          bad = 0;
    int          stall_n = 0;
    bit          rdy_rand = 1'b0;
    bit          noise_en = 1'b0;
    bit          abort_flag = 1'b0;

    always #5 clk = ~clk;

    sqrt2_host #(.DRIVE_CYCLES(DRV), .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)) dut (
        .CLK(clk), .RESET(rst), .IN_VALID(in_vld), .IN_READY(in_rdy), .IN_DATA(in_dat),
        .OUT_VALID(out_vld), .OUT_READY(out_rdy), .OUT_DATA(out_dat), .OUT_NAN(out_nan),
        .OUT_PINF(out_pinf), .OUT_NINF(out_ninf), .OUT_TIMEOUT(out_tmo), .IO_DATA(io_data),
        .ENABLE(enable), .IS_NAN(is_nan), .IS_PINF(is_pinf), .IS_NINF(is_ninf), .RESULT(result)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // Correctly rounded binary16 square root, computed in real arithmetic.
    function automatic logic [18:0] sqrt_ref(input logic [15:0] x);
        real v, r, p;
        int ex, mi;
        logic [4:0] e;
        logic [9:0] m;
        e = x[14:10];
        m = x[9:0];
        if (e == 5'h1f && m != 10'd0) return {16'h7E00, 3'b100};
        if (x[14:0] == 15'd0) return {x, 3'b000};
        if (x[15]) return {16'h7E00, 3'b100};
        if (e == 5'h1f) return {16'h7C00, 3'b010};
        if (e == 5'd0) begin
            v = real'(m);
            ex = -24;
        end else begin
            v = 1024.0 + real'(m);
            ex = int'(e) - 25;
        end
        while (ex > 0) begin v = v * 2.0; ex--; end
        while (ex < 0) begin v = v / 2.0; ex++; end
        r = $sqrt(v);
        p = 1.0;
        ex = 0;
        while (r >= 2.0 * p) begin p = p * 2.0; ex++; end
        while (r < p) begin p = p / 2.0; ex--; end
        mi = $rtoi((r / p - 1.0) * 1024.0 + 0.5);
        if (mi >= 1024) begin
            mi = 0;
            ex++;
        end
        return {1'b0, 5'(ex + 15), 10'(mi), 3'b000};
    endfunction

    // Offer one operand; junk on IN_DATA while the host is busy must be ignored.
    task automatic send(input logic [15:0] op, input int lat, input bit ovr,
                        input logic [15:0] od, input logic [2:0] of);
        txn_t t;
        logic [18:0] r;
        int n;
        n = 0;
        r = ovr ? {od, of} : sqrt_ref(op);
        t.op = op;
        t.lat = lat;
        t.rd = r[18:3];
        t.rf = r[2:0];
        in_vld = 1'b1;
        while (1) begin
            if (in_rdy) begin
                in_dat = op;
                txq.push_back(t);
                if (lat >= 0 && lat < TMO) expq.push_back({r, 1'b0});
                else expq.push_back({16'h7E00, 4'b1001});
                @(negedge clk);
                chk("enable_after_accept", 32'(enable), 32'd1);
                break;
            end
            in_dat = 16'($urandom);
            @(negedge clk);
            n++;
            if (n > 300) begin
                chk("accept_timeout", 32'(n), 32'd0);
                break;
            end
        end
        in_vld = 1'b0;
        in_dat = 16'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(expq.size()), 32'd0);
    endtask

    task automatic probe_bus(input logic [15:0] v);
        prb_val = v;
        prb_drv = 1'b1;
        #1;
        chk("bus_released", 32'(io_data), 32'(v));
        prb_drv = 1'b0;
    endtask

    // Behavioural sqrt2 unit: checks operand phase, answers in WAIT, checks ENABLE timing.
    initial begin
        bit busy;
        int k, lowcnt;
        txn_t t;
        logic en, ov, ir;
        logic [15:0] bus;
        busy = 1'b0;
        k = 0;
        lowcnt = 1000;
        forever begin
            @(negedge clk);
            en = enable; ov = out_vld; ir = in_rdy; bus = io_data;
            bus_drv = 1'b0;
            res_drv = 1'b0;
            res_noise = 1'b0;
            rflg = 3'($urandom);
            if (busy && !en) begin
                if (!abort_flag) begin
                    chk("enable_len", 32'(k),
                        32'((t.lat >= 0 && t.lat < TMO) ? DRV + t.lat + 1 : DRV + TMO));
                    chk("valid_after_enable", 32'(ov), 32'd1);
                end else begin
                    lowcnt = 1000;
                end
                abort_flag = 1'b0;
                busy = 1'b0;
            end
            if (!busy && !en) lowcnt++;
            if (!busy && en) begin
                chk("enable_gap", 32'(lowcnt >= GAP + 2), 32'd1);
                if (txq.size() == 0) begin
                    chk("spurious_enable", 32'd1, 32'd0);
                    t.op = 16'd0; t.lat = -1; t.rd = 16'd0; t.rf = 3'd0;
                end else begin
                    t = txq.pop_front();
                end
                busy = 1'b1;
                k = 0;
                lowcnt = 0;
            end
            if (busy) begin
                chk("in_ready_busy", 32'(ir), 32'd0);
                if (k < DRV) begin
                    chk("bus_operand", 32'(bus), 32'(t.op));
                    res_noise = noise_en ? 1'($urandom) : 1'b0;
                end else if (t.lat >= 0 && k == DRV + t.lat) begin
                    bus_val = t.rd;
                    bus_drv = 1'b1;
                    rflg = t.rf;
                    res_drv = 1'b1;
                end
                k++;
            end else begin
                res_noise = noise_en ? 1'($urandom) : 1'b0;
            end
        end
    end

    // Result monitor: drives OUT_READY, checks hold-while-stalled and pops expectations.
    initial begin
        logic [19:0] hv, act, e;
        bit held, xfer;
        held = 1'b0;
        xfer = 1'b0;
        out_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (out_vld && stall_n > 0) begin
                out_rdy = 1'b0;
                stall_n--;
            end else begin
                out_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            #1;
            act = {out_dat, out_nan, out_pinf, out_ninf, out_tmo};
            if (xfer) chk("valid_drop", 32'(out_vld), 32'd0);
            xfer = 1'b0;
            if (out_vld) begin
                chk("in_ready_resp", 32'(in_rdy), 32'd0);
                chk("enable_resp", 32'(enable), 32'd0);
                if (held) chk("hold_stable", 32'(act), 32'(hv));
                if (out_rdy) begin
                    if (expq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got %h want none at %0t", act, $time);
                    end else begin
                        e = expq.pop_front();
                        chk("result", 32'(act), 32'(e));
                    end
                    held = 1'b0;
                    xfer = 1'b1;
                end else begin
                    held = 1'b1;
                    hv = act;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] op;
        int lat, sel;
        rst = 1'b1;
        in_vld = 1'b0;
        in_dat = 16'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_rdy), 32'd0);
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_out_valid", 32'(out_vld), 32'd0);
        chk("rst_out", 32'({out_dat, out_nan, out_pinf, out_ninf, out_tmo}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_rdy), 32'd1);
        probe_bus(16'hA5C3);
        @(negedge clk);

        send(16'h4400, 2, 1'b0, 16'd0, 3'd0);       // sqrt(4) = 2
        drain();
        send(16'h3C00, 1, 1'b0, 16'd0, 3'd0);       // back-to-back
        send(16'h4C00, 4, 1'b0, 16'd0, 3'd0);
        send(16'h7C00, 0, 1'b0, 16'd0, 3'd0);
        send(16'hC000, 3, 1'b0, 16'd0, 3'd0);
        send(16'h8000, 1, 1'b0, 16'd0, 3'd0);
        send(16'h4200, -1, 1'b0, 16'd0, 3'd0);      // never answers
        drain();
        stall_n = 5;
        send(16'h5000, 2, 1'b0, 16'd0, 3'd0);       // consumer stall
        drain();
        chk("stall_used", 32'(stall_n), 32'd0);
        send(16'h3800, TMO - 1, 1'b0, 16'd0, 3'd0); // result on expiry edge
        send(16'h3800, TMO, 1'b0, 16'd0, 3'd0);     // one cycle too late
        send(16'h1234, 0, 1'b1, 16'hBEEF, 3'b001);  // flag passthrough
        drain();

        // Reset in the middle of WAIT, then a stray RESULT pulse.
        send(16'h4400, 20, 1'b0, 16'd0, 3'd0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        abort_flag = 1'b1;
        void'(expq.pop_back());
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_enable", 32'(enable), 32'd0);
        chk("mid_rst_valid", 32'(out_vld), 32'd0);
        chk("mid_rst_in_ready", 32'(in_rdy), 32'd1);
        chk("mid_rst_out", 32'({out_dat, out_nan, out_pinf, out_ninf, out_tmo}), 32'd0);
        probe_bus(16'hBBFF);
        @(negedge clk);
        res_man = 1'b1;
        @(negedge clk);
        res_man = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            chk("no_late_out", 32'(out_vld), 32'd0);
        end

        rdy_rand = 1'b1;
        noise_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op = 16'($urandom);
            if ($urandom_range(0, 9) < 6) op[15] = 1'b0;
            sel = int'($urandom_range(0, 19));
            if (sel < 15) lat = int'($urandom_range(0, 8));
            else if (sel < 17) lat = TMO - 1;
            else if (sel < 18) lat = TMO;
            else lat = -1;
            if ($urandom_range(0, 6) == 0)
                send(op, lat, 1'b1, 16'($urandom), 3'($urandom));
            else
                send(op, lat, 1'b0, 16'd0, 3'd0);
        end
        drain();
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
